// File: rtl/csr_file.sv
// Machine-mode CSR file: read-modify-write execute, cycle/instret counters, registered readback.
// Optional: define CSR_COUNTERS_EN to implement mcycle/mcycleh/minstret/minstreth.
module csr_file #(
   parameter logic [31:0] MISA_VALUE = 32'h4000_0100,
   parameter logic [31:0] HART_ID    = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        csr_read_enable,
   input  logic        csr_write_enable,
   input  logic [1:0]  csr_write_func,
   input  logic        csr_input_sel,
   input  logic [11:0] csr_addr,
   input  logic [31:0] rs1_value,
   input  logic [4:0]  uimm,
   input  logic        instr_retire,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        illegal
);

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] FUNC_NONE = 2'b00;
   localparam logic [1:0] FUNC_RW   = 2'b01;
   localparam logic [1:0] FUNC_RS   = 2'b10;
   localparam logic [1:0] FUNC_RC   = 2'b11;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MISA      = 12'h301;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

   logic            mstatus_mie;
   logic            mstatus_mpie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mscratch;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] mcause;

   logic [XLEN-1:0] src_c;
   logic [XLEN-1:0] old_value_c;
   logic [XLEN-1:0] new_value_c;
   logic            mapped_c;
   logic            op_en_c;
   logic            illegal_c;
   logic            write_c;

`ifdef CSR_COUNTERS_EN
   logic [XLEN-1:0] mcycle_lo;
   logic [XLEN-1:0] mcycle_hi;
   logic [XLEN-1:0] minstret_lo;
   logic [XLEN-1:0] minstret_hi;
`else
   logic unused_instr_retire;
   assign unused_instr_retire = instr_retire;
`endif

   // Address decode, old-value mux and read-modify-write
   always_comb begin
      src_c       = csr_input_sel ? {27'b0, uimm} : rs1_value;
      old_value_c = '0;
      mapped_c    = 1'b1;
      case (csr_addr)
         ADDR_MSTATUS:   old_value_c = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
         ADDR_MISA:      old_value_c = MISA_VALUE;
         ADDR_MTVEC:     old_value_c = mtvec;
         ADDR_MSCRATCH:  old_value_c = mscratch;
         ADDR_MEPC:      old_value_c = mepc;
         ADDR_MCAUSE:    old_value_c = mcause;
         ADDR_MHARTID:   old_value_c = HART_ID;
`ifdef CSR_COUNTERS_EN
         ADDR_MCYCLE:    old_value_c = mcycle_lo;
         ADDR_MCYCLEH:   old_value_c = mcycle_hi;
         ADDR_MINSTRET:  old_value_c = minstret_lo;
         ADDR_MINSTRETH: old_value_c = minstret_hi;
`endif
         default:        mapped_c    = 1'b0;
      endcase

      case (csr_write_func)
         FUNC_RW: new_value_c = src_c;
         FUNC_RS: new_value_c = old_value_c | src_c;
         FUNC_RC: new_value_c = old_value_c & ~src_c;
         default: new_value_c = old_value_c;
      endcase

      op_en_c   = in_valid & (csr_read_enable | csr_write_enable);
      illegal_c = op_en_c & (~mapped_c | (csr_write_enable & (csr_addr[11:10] == 2'b11)));
      write_c   = op_en_c & csr_write_enable & (csr_write_func != FUNC_NONE) & ~illegal_c;
   end

   // Registered response and architectural CSR state
   always_ff @(posedge clk) begin
      if (reset) begin
         read_data    <= '0;
         read_valid   <= 1'b0;
         illegal      <= 1'b0;
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mtvec        <= '0;
         mscratch     <= '0;
         mepc         <= '0;
         mcause       <= '0;
      end else begin
         read_data  <= (op_en_c & ~illegal_c) ? old_value_c : '0;
         read_valid <= op_en_c & csr_read_enable & ~illegal_c;
         illegal    <= illegal_c;
         if (write_c) begin
            case (csr_addr)
               ADDR_MSTATUS: begin
                  mstatus_mie  <= new_value_c[3];
                  mstatus_mpie <= new_value_c[7];
               end
               ADDR_MTVEC:    mtvec    <= {new_value_c[XLEN-1:2], 2'b00};
               ADDR_MSCRATCH: mscratch <= new_value_c;
               ADDR_MEPC:     mepc     <= {new_value_c[XLEN-1:2], 2'b00};
               ADDR_MCAUSE:   mcause   <= new_value_c;
               default: ;
            endcase
         end
      end
   end

`ifdef CSR_COUNTERS_EN
   logic wr_cycle_lo_c;
   logic wr_cycle_hi_c;
   logic wr_instret_lo_c;
   logic wr_instret_hi_c;

   assign wr_cycle_lo_c   = write_c & (csr_addr == ADDR_MCYCLE);
   assign wr_cycle_hi_c   = write_c & (csr_addr == ADDR_MCYCLEH);
   assign wr_instret_lo_c = write_c & (csr_addr == ADDR_MINSTRET);
   assign wr_instret_hi_c = write_c & (csr_addr == ADDR_MINSTRETH);

   // A write to a half replaces that cycle's increment and blocks carry out of it
   always_ff @(posedge clk) begin
      if (reset) begin
         mcycle_lo   <= '0;
         mcycle_hi   <= '0;
         minstret_lo <= '0;
         minstret_hi <= '0;
      end else begin
         if (wr_cycle_lo_c)
            mcycle_lo <= new_value_c;
         else
            mcycle_lo <= mcycle_lo + XLEN'(1);

         if (wr_cycle_hi_c)
            mcycle_hi <= new_value_c;
         else if (!wr_cycle_lo_c && (mcycle_lo == '1))
            mcycle_hi <= mcycle_hi + XLEN'(1);

         if (wr_instret_lo_c)
            minstret_lo <= new_value_c;
         else if (instr_retire)
            minstret_lo <= minstret_lo + XLEN'(1);

         if (wr_instret_hi_c)
            minstret_hi <= new_value_c;
         else if (!wr_instret_lo_c && instr_retire && (minstret_lo == '1))
            minstret_hi <= minstret_hi + XLEN'(1);
      end
   end
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; counter tests run when CSR_COUNTERS_EN is defined.
module tb_csr_file;

   localparam logic [1:0] F_NONE = 2'b00;
   localparam logic [1:0] F_RW   = 2'b01;
   localparam logic [1:0] F_RS   = 2'b10;
   localparam logic [1:0] F_RC   = 2'b11;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        csr_read_enable;
   logic        csr_write_enable;
   logic [1:0]  csr_write_func;
   logic        csr_input_sel;
   logic [11:0] csr_addr;
   logic [31:0] rs1_value;
   logic [4:0]  uimm;
   logic        instr_retire;
   logic [31:0] read_data;
   logic        read_valid;
   logic        illegal;

   int checks;
   int fails;

   csr_file dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .csr_read_enable  (csr_read_enable),
      .csr_write_enable (csr_write_enable),
      .csr_write_func   (csr_write_func),
      .csr_input_sel    (csr_input_sel),
      .csr_addr         (csr_addr),
      .rs1_value        (rs1_value),
      .uimm             (uimm),
      .instr_retire     (instr_retire),
      .read_data        (read_data),
      .read_valid       (read_valid),
      .illegal          (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      in_valid         = 1'b0;
      csr_read_enable  = 1'b0;
      csr_write_enable = 1'b0;
      csr_write_func   = F_NONE;
      csr_input_sel    = 1'b0;
      csr_addr         = 12'h0;
      rs1_value        = 32'h0;
      uimm             = 5'h0;
   endtask

   // Present one operation for one cycle; returns 1 time unit after the edge with outputs settled
   task automatic do_op(input logic re, input logic we, input logic [1:0] fn, input logic sel,
                        input logic [11:0] addr, input logic [31:0] rs1, input logic [4:0] imm);
      in_valid         = 1'b1;
      csr_read_enable  = re;
      csr_write_enable = we;
      csr_write_func   = fn;
      csr_input_sel    = sel;
      csr_addr         = addr;
      rs1_value        = rs1;
      uimm             = imm;
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic idle(input int n);
      clear_inputs();
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      instr_retire = 1'b0;
      clear_inputs();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (read_data !== 32'h0) begin fails++; $display("FAIL reset_read_data: got %h expected %h", read_data, 32'h0); end
      checks++; if (read_valid !== 1'b0) begin fails++; $display("FAIL reset_read_valid: got %b expected 0", read_valid); end
      checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
      reset = 1'b0;
   endtask

   task automatic test_rw_mscratch();
      do_op(1'b1, 1'b1, F_RW, 1'b0, 12'h340, 32'hDEADBEEF, 5'h0);
      checks++; if (read_data !== 32'h0) begin fails++; $display("FAIL rw_old_value: got %h expected %h", read_data, 32'h0); end
      checks++; if (read_valid !== 1'b1) begin fails++; $display("FAIL rw_read_valid: got %b expected 1", read_valid); end
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h340, 32'h0, 5'h0);
      checks++; if (read_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rw_readback: got %h expected %h", read_data, 32'hDEADBEEF); end
   endtask

   task automatic test_mstatus();
      do_op(1'b1, 1'b1, F_RS, 1'b1, 12'h300, 32'h0, 5'h1F);
      checks++; if (read_data !== 32'h0) begin fails++; $display("FAIL mstatus_initial: got %h expected %h", read_data, 32'h0); end
      do_op(1'b1, 1'b1, F_RC, 1'b1, 12'h300, 32'h0, 5'h08);
      checks++; if (read_data !== 32'h08) begin fails++; $display("FAIL mstatus_after_rsi: got %h expected %h", read_data, 32'h08); end
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h300, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h0) begin fails++; $display("FAIL mstatus_after_rci: got %h expected %h", read_data, 32'h0); end
      do_op(1'b0, 1'b1, F_RS, 1'b0, 12'h300, 32'hFFFFFFFF, 5'h0);
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h300, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h88) begin fails++; $display("FAIL mstatus_mask: got %h expected %h", read_data, 32'h88); end
   endtask

   task automatic test_masks();
      do_op(1'b0, 1'b1, F_RW, 1'b0, 12'h305, 32'hFFFFFFFF, 5'h0);
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h305, 32'h0, 5'h0);
      checks++; if (read_data !== 32'hFFFFFFFC) begin fails++; $display("FAIL mtvec_mask: got %h expected %h", read_data, 32'hFFFFFFFC); end
      do_op(1'b0, 1'b1, F_RW, 1'b0, 12'h341, 32'h12345677, 5'h0);
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h341, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h12345674) begin fails++; $display("FAIL mepc_mask: got %h expected %h", read_data, 32'h12345674); end
      do_op(1'b0, 1'b1, F_RW, 1'b0, 12'h342, 32'h8000000B, 5'h0);
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h342, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h8000000B) begin fails++; $display("FAIL mcause_full: got %h expected %h", read_data, 32'h8000000B); end
      do_op(1'b1, 1'b1, F_RW, 1'b0, 12'h301, 32'h0, 5'h0);
      checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL misa_write_legal: got %b expected 0", illegal); end
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h301, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h40000100) begin fails++; $display("FAIL misa_value: got %h expected %h", read_data, 32'h40000100); end
   endtask

   task automatic test_back_to_back();
      do_op(1'b1, 1'b1, F_RW, 1'b0, 12'h340, 32'h00000011, 5'h0);
      checks++; if (read_data !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_first: got %h expected %h", read_data, 32'hDEADBEEF); end
      do_op(1'b1, 1'b1, F_RS, 1'b0, 12'h340, 32'h00000022, 5'h0);
      checks++; if (read_data !== 32'h00000011) begin fails++; $display("FAIL b2b_second: got %h expected %h", read_data, 32'h00000011); end
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h340, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h00000033) begin fails++; $display("FAIL b2b_third: got %h expected %h", read_data, 32'h00000033); end
   endtask

   task automatic test_no_change();
      in_valid = 1'b0; csr_read_enable = 1'b1; csr_write_enable = 1'b1;
      csr_write_func = F_RW; csr_addr = 12'h340; rs1_value = 32'h5A5A5A5A;
      @(posedge clk); #1;
      checks++; if (read_valid !== 1'b0) begin fails++; $display("FAIL novalid_read_valid: got %b expected 0", read_valid); end
      clear_inputs();
      do_op(1'b1, 1'b1, F_NONE, 1'b0, 12'h340, 32'hFFFFFFFF, 5'h0);
      checks++; if (read_data !== 32'h00000033) begin fails++; $display("FAIL none_old_value: got %h expected %h", read_data, 32'h00000033); end
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h340, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h00000033) begin fails++; $display("FAIL no_change_value: got %h expected %h", read_data, 32'h00000033); end
   endtask

   task automatic test_illegal();
      do_op(1'b1, 1'b1, F_RW, 1'b0, 12'hF14, 32'h55, 5'h0);
      checks++; if (illegal !== 1'b1) begin fails++; $display("FAIL ro_write_illegal: got %b expected 1", illegal); end
      checks++; if (read_valid !== 1'b0) begin fails++; $display("FAIL ro_write_read_valid: got %b expected 0", read_valid); end
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h7C0, 32'h0, 5'h0);
      checks++; if (illegal !== 1'b1) begin fails++; $display("FAIL unmapped_illegal: got %b expected 1", illegal); end
      checks++; if (read_data !== 32'h0) begin fails++; $display("FAIL unmapped_read_data: got %h expected %h", read_data, 32'h0); end
      idle(1);
      checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL illegal_one_cycle: got %b expected 0", illegal); end
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'hF14, 32'h0, 5'h0);
      checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL hartid_read_illegal: got %b expected 0", illegal); end
      checks++; if (read_valid !== 1'b1) begin fails++; $display("FAIL hartid_read_valid: got %b expected 1", read_valid); end
      checks++; if (read_data !== 32'h0) begin fails++; $display("FAIL hartid_value: got %h expected %h", read_data, 32'h0); end
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h340, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h00000033) begin fails++; $display("FAIL illegal_no_state: got %h expected %h", read_data, 32'h00000033); end
   endtask

`ifdef CSR_COUNTERS_EN
   task automatic test_mcycle_carry();
      do_op(1'b0, 1'b1, F_RW, 1'b0, 12'hB00, 32'hFFFFFFFE, 5'h0);
      do_op(1'b0, 1'b1, F_RW, 1'b0, 12'hB80, 32'h0, 5'h0);
      idle(2);
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'hB80, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h1) begin fails++; $display("FAIL mcycleh_carry: got %h expected %h", read_data, 32'h1); end
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'hB00, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h2) begin fails++; $display("FAIL mcycle_after_wrap: got %h expected %h", read_data, 32'h2); end
   endtask

   task automatic test_minstret();
      instr_retire = 1'b1;
      do_op(1'b0, 1'b1, F_RW, 1'b0, 12'hB02, 32'h10, 5'h0);
      idle(3);
      instr_retire = 1'b0;
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'hB02, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h13) begin fails++; $display("FAIL minstret_count: got %h expected %h", read_data, 32'h13); end
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'hB82, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h0) begin fails++; $display("FAIL minstreth_value: got %h expected %h", read_data, 32'h0); end
   endtask
`else
   task automatic test_counters_absent();
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'hB00, 32'h0, 5'h0);
      checks++; if (illegal !== 1'b1) begin fails++; $display("FAIL mcycle_absent_illegal: got %b expected 1", illegal); end
      checks++; if (read_data !== 32'h0) begin fails++; $display("FAIL mcycle_absent_data: got %h expected %h", read_data, 32'h0); end
      checks++; if (read_valid !== 1'b0) begin fails++; $display("FAIL mcycle_absent_valid: got %b expected 0", read_valid); end
      do_op(1'b0, 1'b1, F_RW, 1'b0, 12'hB82, 32'h1, 5'h0);
      checks++; if (illegal !== 1'b1) begin fails++; $display("FAIL minstreth_absent_illegal: got %b expected 1", illegal); end
   endtask
`endif

   task automatic test_reset_mid_op();
      in_valid = 1'b1; csr_read_enable = 1'b1; csr_write_enable = 1'b1;
      csr_write_func = F_RW; csr_addr = 12'hF14; rs1_value = 32'h1234;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL midreset_illegal: got %b expected 0", illegal); end
      checks++; if (read_valid !== 1'b0) begin fails++; $display("FAIL midreset_read_valid: got %b expected 0", read_valid); end
      reset = 1'b0;
      clear_inputs();
      do_op(1'b1, 1'b0, F_RS, 1'b0, 12'h340, 32'h0, 5'h0);
      checks++; if (read_data !== 32'h0) begin fails++; $display("FAIL midreset_mscratch: got %h expected %h", read_data, 32'h0); end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_rw_mscratch();
      test_mstatus();
      test_masks();
      test_back_to_back();
      test_no_change();
      test_illegal();
`ifdef CSR_COUNTERS_EN
      test_mcycle_carry();
      test_minstret();
`else
      test_counters_absent();
`endif
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
